imm_gen_stage: RTL

//  Registered, parametrised immediate generator between decode and execute.

---
 rtl/imm_gen_stage_pkg.sv | 28 ++
 rtl/imm_gen_stage_if.sv | 27 ++
 rtl/imm_gen_stage_decode.sv | 53 +++++
 rtl/imm_gen_stage.sv | 127 ++++++++++++
 4 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate generator stage: format codes, FSM states, XLEN check.
// Compressed codes (IMM_CI..IMM_CB) only decode when IMM_GEN_RVC_EN is defined.
package imm_gen_stage_pkg;

    localparam logic [3:0] IMM_I   = 4'b0000;
    localparam logic [3:0] IMM_S   = 4'b0001;
    localparam logic [3:0] IMM_B   = 4'b0010;
    localparam logic [3:0] IMM_U   = 4'b0011;
    localparam logic [3:0] IMM_J   = 4'b0100;
    localparam logic [3:0] IMM_Z   = 4'b0101;
    localparam logic [3:0] IMM_SH  = 4'b0110;
    localparam logic [3:0] IMM_CI  = 4'b1000;
    localparam logic [3:0] IMM_CL  = 4'b1001;
    localparam logic [3:0] IMM_CIW = 4'b1010;
    localparam logic [3:0] IMM_CJ  = 4'b1011;
    localparam logic [3:0] IMM_CB  = 4'b1100;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    function automatic bit xlen_ok(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Decode-side and execute-side handshake bundle of the immediate generator stage.
// master = producer/consumer environment, slave = the stage itself.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             InValid;
    logic             InReady;
    logic [31:0]      Instr;
    logic [3:0]       ImmSrc;
    logic [TAG_W-1:0] InTag;
    logic             OutValid;
    logic             OutReady;
    logic [XLEN-1:0]  ImmExt;
    logic [TAG_W-1:0] OutTag;
    logic             ImmErr;

    modport master (
        output InValid, Instr, ImmSrc, InTag, OutReady,
        input  InReady, OutValid, ImmExt, OutTag, ImmErr
    );

    modport slave (
        input  InValid, Instr, ImmSrc, InTag, OutReady,
        output InReady, OutValid, ImmExt, OutTag, ImmErr
    );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: builds a 32-bit immediate, then sign-extends to XLEN.
// Compressed formats are decoded only when IMM_GEN_RVC_EN is defined.
module imm_gen_stage_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [3:0]      i_imm_src,
    output logic [XLEN-1:0] o_imm_ext,
    output logic            o_imm_err
);
    logic [31:0] w_imm32;
    logic        w_err;
    logic        w_unused_opcode;

    assign w_unused_opcode = ^i_instr[6:0];

    // Zero-extended formats keep bit 31 clear, so one sign-extension covers every format.
    always_comb begin
        w_imm32 = '0;
        w_err   = 1'b0;
        case (i_imm_src)
            IMM_I:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:  w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                               i_instr[11:8], 1'b0};
            IMM_U:  w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:  w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                               i_instr[30:21], 1'b0};
            IMM_Z:  w_imm32 = {27'b0, i_instr[19:15]};
            IMM_SH: w_imm32 = (XLEN == 64) ? {26'b0, i_instr[25:20]} : {27'b0, i_instr[24:20]};
`ifdef IMM_GEN_RVC_EN
            IMM_CI:  w_imm32 = {{26{i_instr[12]}}, i_instr[12], i_instr[6:2]};
            IMM_CL:  w_imm32 = {25'b0, i_instr[5], i_instr[12:10], i_instr[6], 2'b0};
            IMM_CIW: w_imm32 = {22'b0, i_instr[10:7], i_instr[12:11], i_instr[5], i_instr[6], 2'b0};
            IMM_CJ:  w_imm32 = {{20{i_instr[12]}}, i_instr[12], i_instr[8], i_instr[10:9],
                                i_instr[6], i_instr[7], i_instr[2], i_instr[11], i_instr[5:3], 1'b0};
            IMM_CB:  w_imm32 = {{23{i_instr[12]}}, i_instr[12], i_instr[6:5], i_instr[2],
                                i_instr[11:10], i_instr[4:3], 1'b0};
`endif
            default: w_err = 1'b1;
        endcase
    end

    assign o_imm_ext[31:0] = w_imm32;
    assign o_imm_err       = w_err;

    if (XLEN > 32) begin : g_ext
        assign o_imm_ext[XLEN-1:32] = {(XLEN-32){w_imm32[31]}};
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry (output + skid) lossless handshake buffer.
// Optional compressed formats: define IMM_GEN_RVC_EN (handled in imm_gen_stage_decode).
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    imm_gen_stage_if.slave   bus
);
    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    stage_state_e     r_state;
    stage_state_e     w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [XLEN-1:0]  r_skid_imm;
    logic [XLEN-1:0]  w_dec_imm;
    logic             r_out_err;
    logic             r_skid_err;
    logic             w_dec_err;
    logic [TAG_W-1:0] r_out_tag;
    logic [TAG_W-1:0] r_skid_tag;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_in;
    logic             w_load_skid;
    logic             w_load_from_skid;

    imm_gen_stage_decode #(.XLEN(XLEN)) u_decode (
        .i_instr   (bus.Instr),
        .i_imm_src (bus.ImmSrc),
        .o_imm_ext (w_dec_imm),
        .o_imm_err (w_dec_err)
    );

    assign w_in_fire  = bus.InValid && r_in_ready;
    assign w_out_fire = r_out_valid && bus.OutReady;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_in        = 1'b0;
        w_load_skid      = 1'b0;
        w_load_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_load_in   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_ONE;
                        w_load_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Ready/valid are registered copies of the next state so no comb path reaches InReady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_imm  <= '0;
            r_out_err  <= 1'b0;
            r_out_tag  <= '0;
            r_skid_imm <= '0;
            r_skid_err <= 1'b0;
            r_skid_tag <= '0;
        end else begin
            if (w_load_in) begin
                r_out_imm <= w_dec_imm;
                r_out_err <= w_dec_err;
                r_out_tag <= bus.InTag;
            end else if (w_load_from_skid) begin
                r_out_imm <= r_skid_imm;
                r_out_err <= r_skid_err;
                r_out_tag <= r_skid_tag;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_dec_imm;
                r_skid_err <= w_dec_err;
                r_skid_tag <= bus.InTag;
            end
        end
    end

    assign bus.InReady  = r_in_ready;
    assign bus.OutValid = r_out_valid;
    assign bus.ImmExt   = r_out_imm;
    assign bus.OutTag   = r_out_tag;
    assign bus.ImmErr   = r_out_err;

endmodule
